// File: rtl/scrolling_block_drawer.sv
// scrolling_block_drawer: draws a solid WIDTH x HEIGHT rectangle pixel by pixel on request and scrolls it left on each frame
// Ports: clock/reset (async, active-high); enable gates scrolling; update_screen requests a scroll step;
//        draw_start/draw_done form the draw handshake; plot qualifies send_x/send_y/send_colour.
module scrolling_block_drawer #(
  parameter logic [10:0] START_X = 11'd150,
  parameter logic [10:0] START_Y = 11'd100,
  parameter logic [10:0] WIDTH   = 11'd8,
  parameter logic [10:0] HEIGHT  = 11'd8,
  parameter logic [10:0] STEP    = 11'd1,
  parameter logic [2:0]  COLOUR  = 3'b111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        update_screen,
  input  logic        draw_start,
  output logic        draw_done,
  output logic        plot,
  output logic [10:0] send_x,
  output logic [10:0] send_y,
  output logic [2:0]  send_colour
);
  localparam logic [1:0] IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [10:0] x_q, x_d, draw_x_q, draw_x_d, cx_q, cx_d, cy_q, cy_d;
  logic        pend_q, pend_d, last_col, last, apply;
  // the scroll step is only applied while idle with no request pending, so the position is frozen for a whole draw
  always_comb begin
    last_col = cx_q == WIDTH - 11'd1;
    last     = last_col && cy_q == HEIGHT - 11'd1;
    apply    = enable && pend_q && state_q == IDLE && !draw_start;
    state_d  = state_q == IDLE ? (draw_start ? DRAW : IDLE) :
               state_q == DRAW ? (last ? DONE : DRAW) :
               (draw_start ? DONE : IDLE);
    cx_d     = state_q == DRAW && !last_col ? cx_q + 11'd1 : 11'd0;
    cy_d     = state_q == DRAW ? (last_col ? cy_q + 11'd1 : cy_q) : 11'd0;
    draw_x_d = state_q == IDLE && draw_start ? x_q : draw_x_q;
    x_d      = apply ? (x_q <= STEP ? START_X : x_q - STEP) : x_q;
    pend_d   = (enable && update_screen) || (pend_q && !apply);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= START_X;
      draw_x_q <= START_X;
      cx_q     <= '0;
      cy_q     <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      draw_x_q <= draw_x_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      pend_q   <= pend_d;
    end
  end
  assign plot        = state_q == DRAW;
  assign draw_done   = state_q == DONE;
  assign send_x      = plot ? draw_x_q + cx_q : x_q;
  assign send_y      = plot ? START_Y + cy_q : START_Y;
  assign send_colour = COLOUR;
endmodule

// File: tb/tb_scrolling_block_drawer.sv
// tb_scrolling_block_drawer: randomized self-checking bench against a transaction-level position/pixel model
module tb_scrolling_block_drawer;
  localparam int SX = 10, SY = 20, W = 4, H = 2, ST = 1;
  localparam logic [2:0] COL = 3'b101;
  logic clock = 0, reset = 0, enable = 0, update_screen = 0, draw_start = 0;
  logic draw_done, plot;
  logic [10:0] send_x, send_y;
  logic [2:0] send_colour;
  int checks = 0, errors = 0, mx = SX;
  scrolling_block_drawer #(
    .START_X(11'd10), .START_Y(11'd20), .WIDTH(11'd4), .HEIGHT(11'd2), .STEP(11'd1), .COLOUR(COL)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .update_screen(update_screen), .draw_start(draw_start),
    .draw_done(draw_done), .plot(plot), .send_x(send_x), .send_y(send_y), .send_colour(send_colour)
  );
  always #5 clock = ~clock;
  function automatic int step_x(input int x);
    return x <= ST ? SX : x - ST;
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic pulse_idle;
    update_screen = 1;
    tick;
    update_screen = 0;
    tick;
    if (enable) mx = step_x(mx);
    checks++;
    if (int'(send_x) !== mx || plot !== 1'b0) begin
      errors++;
      $display("FAIL idle_scroll: send_x=%0d plot=%b expected send_x=%0d plot=0", send_x, plot, mx);
    end
  endtask
  task automatic run_draw(input int hold, input logic [7:0] pulses);
    int ox;
    logic pend;
    ox = mx;
    pend = 0;
    draw_start = 1;
    tick;
    for (int i = 0; i < W * H; i++) begin
      checks++;
      if (plot !== 1'b1 || int'(send_x) !== ox + i % W || int'(send_y) !== SY + i / W || send_colour !== COL) begin
        errors++;
        $display("FAIL pixel%0d: plot=%b x=%0d y=%0d c=%b expected plot=1 x=%0d y=%0d c=%b",
                 i, plot, send_x, send_y, send_colour, ox + i % W, SY + i / W, COL);
      end
      update_screen = pulses[i];
      if (pulses[i] && enable) pend = 1;
      tick;
      update_screen = 0;
    end
    checks++;
    if (draw_done !== 1'b1 || plot !== 1'b0) begin
      errors++;
      $display("FAIL done_rise: draw_done=%b plot=%b expected 1 0", draw_done, plot);
    end
    for (int i = 0; i < hold; i++) begin
      tick;
      checks++;
      if (draw_done !== 1'b1) begin
        errors++;
        $display("FAIL done_hold%0d: draw_done=%b expected 1", i, draw_done);
      end
    end
    draw_start = 0;
    tick;
    checks++;
    if (draw_done !== 1'b0 || plot !== 1'b0 || int'(send_x) !== ox) begin
      errors++;
      $display("FAIL done_fall: draw_done=%b plot=%b x=%0d expected 0 0 %0d", draw_done, plot, send_x, ox);
    end
    tick;
    if (pend) mx = step_x(mx);
    checks++;
    if (int'(send_x) !== mx || int'(send_y) !== SY) begin
      errors++;
      $display("FAIL post_draw_pos: x=%0d y=%0d expected %0d %0d", send_x, send_y, mx, SY);
    end
  endtask
  task automatic test_reset;
    reset = 1;
    tick;
    reset = 0;
    tick;
    checks++;
    if (plot !== 1'b0 || draw_done !== 1'b0 || int'(send_x) !== SX || int'(send_y) !== SY || send_colour !== COL) begin
      errors++;
      $display("FAIL reset_idle: plot=%b done=%b x=%0d y=%0d expected 0 0 %0d %0d", plot, draw_done, send_x, send_y, SX, SY);
    end
    draw_start = 1;
    repeat (4) tick;
    checks++;
    if (plot !== 1'b1 || int'(send_x) !== SX + 3) begin
      errors++;
      $display("FAIL middraw: plot=%b x=%0d expected 1 %0d", plot, send_x, SX + 3);
    end
    reset = 1;
    #1;
    checks++;
    if (plot !== 1'b0 || draw_done !== 1'b0 || int'(send_x) !== SX || int'(send_y) !== SY) begin
      errors++;
      $display("FAIL async_reset: plot=%b done=%b x=%0d y=%0d expected 0 0 %0d %0d", plot, draw_done, send_x, send_y, SX, SY);
    end
    draw_start = 0;
    tick;
    reset = 0;
    tick;
    mx = SX;
    checks++;
    if (plot !== 1'b0 || draw_done !== 1'b0 || int'(send_x) !== SX) begin
      errors++;
      $display("FAIL reset_release: plot=%b done=%b x=%0d expected 0 0 %0d", plot, draw_done, send_x, SX);
    end
  endtask
  task automatic test_full_draw;
    enable = 1;
    run_draw(5, 8'h00);
    run_draw(0, 8'h00);
  endtask
  task automatic test_scroll;
    enable = 1;
    pulse_idle;
    while (mx != 1) pulse_idle;
    pulse_idle;
    checks++;
    if (int'(send_x) !== SX) begin
      errors++;
      $display("FAIL wrap: x=%0d expected %0d", send_x, SX);
    end
  endtask
  task automatic test_back_to_back_pulse;
    enable = 1;
    update_screen = 1;
    tick;
    tick;
    update_screen = 0;
    mx = step_x(mx);
    checks++;
    if (int'(send_x) !== mx) begin
      errors++;
      $display("FAIL same_cycle_first: x=%0d expected %0d", send_x, mx);
    end
    tick;
    mx = step_x(mx);
    checks++;
    if (int'(send_x) !== mx) begin
      errors++;
      $display("FAIL same_cycle_second: x=%0d expected %0d", send_x, mx);
    end
  endtask
  task automatic test_deferred;
    enable = 1;
    run_draw(2, 8'b0000_0100);
    run_draw(0, 8'b0010_0010);
    run_draw(1, 8'b1000_0000);
  endtask
  task automatic test_enable_low;
    enable = 0;
    repeat (3) pulse_idle;
    run_draw(1, 8'hFF);
    enable = 1;
    tick;
    checks++;
    if (int'(send_x) !== mx) begin
      errors++;
      $display("FAIL enable_low_stale: x=%0d expected %0d", send_x, mx);
    end
  endtask
  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      enable = 1'($urandom % 2);
      repeat ($urandom % 3) pulse_idle;
      run_draw(int'($urandom % 4), 8'($urandom));
    end
  endtask
  initial begin
    test_reset;
    test_full_draw;
    test_scroll;
    test_back_to_back_pulse;
    test_deferred;
    test_enable_low;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scrolling_block_drawer.md
Name: scrolling_block_drawer

Overview:
- Responder end of the shape draw handshake. The top-level shape sequencer raises `draw_start` for one shape ID and waits for `draw_done`. It muxes this block's `send_x`/`send_y`/`send_colour` to the VGA adapter.
- Draws one solid WIDTH x HEIGHT rectangle (block or obstacle), one pixel per clock, at its current position.
- Scrolls its own position left by STEP on each screen-update pulse and wraps back to START_X after leaving the screen.
- One instance per block/spike slot in the shape table.

Parameters:
- START_X, 11'd150: x origin after reset and after wrap.
- START_Y, 11'd100: fixed y origin.
- WIDTH, 11'd8: rectangle width in pixels, 1..64.
- HEIGHT, 11'd8: rectangle height in pixels, 1..64.
- STEP, 11'd1: pixels moved left per update pulse, greater than or equal to 1.
- COLOUR, 3'b111: RGB colour driven while plotting.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high; returns the block to START position and IDLE.
- enable, input, 1: game running; while low, position updates are ignored.
- update_screen, input, 1: one-cycle pulse per frame; requests a scroll step.
- draw_start, input, 1: draw request from the sequencer, level held.
- draw_done, output, 1: draw complete, level held.
- plot, output, 1: current send_x/send_y/send_colour is a valid pixel.
- send_x, output, 11: pixel x.
- send_y, output, 11: pixel y.
- send_colour, output, 3: pixel colour.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, x_pos=START_X, y_pos=START_Y.
  - cx=cy=0, pending_step=0.
  - draw_done=0, plot=0, send_x=START_X, send_y=START_Y, send_colour=COLOUR.
- States: IDLE, DRAW, DONE. All registers update on the rising edge of `clock`.
- IDLE:
  - draw_done=0, plot=0; send_x=x_pos, send_y=y_pos.
  - If draw_start=1, go to DRAW next cycle with cx=cy=0. The origin (draw_x, draw_y) is snapshotted from x_pos/y_pos on that edge.
- DRAW:
  - plot=1, send_x=draw_x+cx, send_y=draw_y+cy, send_colour=COLOUR.
  - Each cycle: if cx==WIDTH-1, then cx=0 and cy=cy+1; otherwise cx=cx+1.
  - On the pixel cx==WIDTH-1 and cy==HEIGHT-1, go to DONE. DRAW lasts exactly WIDTH*HEIGHT cycles, row-major order.
  - draw_start is ignored in DRAW; a mid-draw drop does not abort.
- DONE:
  - draw_done=1, plot=0.
  - draw_done stays high while draw_start=1. When draw_start=0, go to IDLE next cycle; draw_done is low from that cycle on.
  - Latency from start to done: draw_start seen high in IDLE at edge N means the first pixel is in cycle N+1 and draw_done is high from cycle N+1+WIDTH*HEIGHT.
- Scroll:
  - An update_screen pulse with enable=1 sets pending_step.
  - pending_step is applied only in IDLE, on the cycle where draw_start=0, and is then cleared.
  - Consequence: position never changes between the start snapshot and draw_done deassertion.
  - Apply rule: if x_pos <= STEP, then x_pos=START_X (wrap); otherwise x_pos=x_pos-STEP. y_pos never changes.
  - Multiple pulses before the step is applied collapse into one step.
  - A pulse arriving on the same cycle that pending_step is applied sets pending_step again; it is not lost.
- Arithmetic: all unsigned 11-bit, no saturation. draw_x+cx may exceed the screen; clipping is the VGA adapter's job.
- enable low: the pending flag is neither set nor applied. Draw handshake still operates.

Test Plan:
- Reset values: assert reset mid-DRAW (cx=3) -> immediately plot=0, draw_done=0, send_x=150, send_y=100; after release, state=IDLE.
- Full draw with WIDTH=4, HEIGHT=2, START=(10,20):
  - Raise draw_start -> 8 plot cycles: (10,20),(11,20),(12,20),(13,20),(10,21),(11,21),(12,21),(13,21).
  - Then draw_done=1 and plot=0.
- Done hold: keep draw_start high 5 extra cycles -> draw_done stays 1. Drop draw_start -> draw_done=0 one cycle later; a new draw_start restarts at (10,20).
- Scroll: enable=1, update_screen pulse in IDLE -> x_pos 150 to 149 within 2 cycles. With STEP=1 and x_pos=1, a pulse -> x_pos=150.
- Deferred update: pulse update_screen during DRAW -> all pixels use the old x. After draw_start drops, x decrements once. Two pulses during one draw -> a single decrement.
- enable=0: 3 update_screen pulses -> x_pos unchanged, draw handshake unaffected.
